button_conditioner: RTL and testbench

// - Upstream stage of the alarm-clock top: conditions raw board push-buttons (reset, load_time,

---
 rtl/clock_pkg.sv | 27 ++
 rtl/debounce_cell.sv | 90 +++++++++
 rtl/button_conditioner.sv | 39 +++
 tb/tb_button_conditioner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
//  Module : clock_pkg
//  Brief  : Shared constants for the alarm-clock front end (button map, timing).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

   localparam int BTN_RESET      = 0;
   localparam int BTN_LOAD_TIME  = 1;
   localparam int BTN_LOAD_ALARM = 2;
   localparam int BTN_STOP_ALARM = 3;
   localparam int N_BTN          = 4;

   localparam int CLK_HZ         = 100_000_000;
   localparam int DB_CYCLES      = CLK_HZ / 100;   // 10 ms settle window
   localparam int HOLD_CYCLES    = CLK_HZ;         // 1 s long-press threshold

   // Counter width that never collapses to zero bits.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_cell.sv
// ============================================================================
//  Module : debounce_cell
//  Brief  : One button: 2-FF sync, counter debounce, press/release pulses, hold.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module debounce_cell
   import clock_pkg::cnt_width;
#(
   parameter int DB_CYCLES   = 4,
   parameter int HOLD_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_hold
);

   localparam int DBW = cnt_width(DB_CYCLES);
   localparam int HW  = cnt_width(HOLD_CYCLES + 1);
   localparam logic [DBW-1:0] c_DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [HW-1:0]  c_HOLD_MAX  = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0]  c_HOLD_LAST = HW'(HOLD_CYCLES - 1);

   if (DB_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_params
      $error("debounce_cell: DB_CYCLES and HOLD_CYCLES must both be >= 2");
   end

   logic           s1_q, s2_q;
   logic           stable_q, stable_d;
   logic [DBW-1:0] db_cnt_q, db_cnt_d;
   logic           press_q, press_d;
   logic           release_q, release_d;
   logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
   logic           hold_q, hold_d;

   always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (s2_q != stable_q) begin
         if (db_cnt_q == c_DB_LAST) stable_d = s2_q;
         else                       db_cnt_d = db_cnt_q + DBW'(1);
      end

      press_d   = stable_d & ~stable_q;
      release_d = ~stable_d & stable_q;

      // Hold is driven from the next level so it drops on the release edge itself.
      hold_cnt_d = '0;
      hold_d     = 1'b0;
      if (stable_d && stable_q) begin
         hold_cnt_d = (hold_cnt_q == c_HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
         hold_d     = (hold_cnt_q >= c_HOLD_LAST);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         stable_q   <= 1'b0;
         db_cnt_q   <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         hold_cnt_q <= '0;
         hold_q     <= 1'b0;
      end else begin
         s1_q       <= btn_in;
         s2_q       <= s1_q;
         stable_q   <= stable_d;
         db_cnt_q   <= db_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         hold_cnt_q <= hold_cnt_d;
         hold_q     <= hold_d;
      end
   end

   assign btn_level   = stable_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_hold    = hold_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
//  Module : button_conditioner
//  Brief  : Array of independent debounce cells for the board push-buttons.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
   parameter int N_BTN       = clock_pkg::N_BTN,
   parameter int DB_CYCLES   = clock_pkg::DB_CYCLES,
   parameter int HOLD_CYCLES = clock_pkg::HOLD_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_hold
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_cell #(
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_cell (
         .clk         (clk),
         .reset       (reset),
         .btn_in      (btn_in[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_hold    (btn_hold[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
//  Module : tb_button_conditioner
//  Brief  : Scoreboard bench for button_conditioner (DB_CYCLES=4, HOLD_CYCLES=16).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

   logic       clk;
   logic       reset;
   logic [3:0] btn_in;
   logic [3:0] btn_level, btn_press, btn_release, btn_hold;
   logic [15:0] dut_out;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int          cyc;
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   button_conditioner #(
      .N_BTN       (4),
      .DB_CYCLES   (4),
      .HOLD_CYCLES (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_hold    (btn_hold)
   );

   assign dut_out = {btn_level, btn_press, btn_release, btn_hold};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] pk(input logic [3:0] lvl, input logic [3:0] prs,
                                      input logic [3:0] rel, input logic [3:0] hld);
      return {lvl, prs, rel, hld};
   endfunction

   task automatic push(input int c, input string tag, input logic [15:0] v);
      exp_t x;
      int   idx;
      x.cyc = c;
      x.tag = tag;
      x.val = v;
      idx   = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, x);
   endtask

   task automatic push_range(input int c_from, input int c_to, input string tag,
                             input logic [15:0] v);
      for (int c = c_from; c <= c_to; c++) push(c, tag, v);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compare each expectation on the falling edge of its cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) check({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
         else             check(e.tag, {16'h0, dut_out}, {16'h0, e.val});
      end
   end

   initial begin
      int c0, c1, r;

      reset  = 1'b1;
      btn_in = 4'b1111;
      #1 check("rst_async", {16'h0, dut_out}, 32'h0);
      push_range(1, 3, "rst_hold", 16'h0);
      step(3);
      btn_in = 4'b0000;
      reset  = 1'b0;
      push_range(cyc + 1, cyc + 8, "post_rst", 16'h0);
      step(10);

      // Clean press on button 1
      c0 = cyc;
      btn_in = 4'b0010;
      push_range(c0 + 1, c0 + 5, "clean_pre", 16'h0);
      push(c0 + 6, "clean_press", pk(4'b0010, 4'b0010, 4'b0000, 4'b0000));
      push_range(c0 + 7, c0 + 10, "clean_lvl", pk(4'b0010, 4'b0000, 4'b0000, 4'b0000));
      step(10);
      c1 = cyc;
      btn_in = 4'b0000;
      push_range(c1 + 1, c1 + 5, "clean_rel_pre", pk(4'b0010, 4'b0000, 4'b0000, 4'b0000));
      push(c1 + 6, "clean_rel", pk(4'b0000, 4'b0000, 4'b0010, 4'b0000));
      push_range(c1 + 7, c1 + 10, "clean_idle", 16'h0);
      step(12);

      // Bounce on button 2
      c0 = cyc;
      push_range(c0 + 1, c0 + 13, "bounce_quiet", 16'h0);
      push(c0 + 14, "bounce_press", pk(4'b0100, 4'b0100, 4'b0000, 4'b0000));
      push_range(c0 + 15, c0 + 18, "bounce_lvl", pk(4'b0100, 4'b0000, 4'b0000, 4'b0000));
      btn_in = 4'b0100; step(2);
      btn_in = 4'b0000; step(2);
      btn_in = 4'b0100; step(2);
      btn_in = 4'b0000; step(2);
      btn_in = 4'b0100; step(10);
      c1 = cyc;
      btn_in = 4'b0000;
      push_range(c1 + 1, c1 + 5, "bounce_rel_pre", pk(4'b0100, 4'b0000, 4'b0000, 4'b0000));
      push(c1 + 6, "bounce_rel", pk(4'b0000, 4'b0000, 4'b0100, 4'b0000));
      push_range(c1 + 7, c1 + 9, "bounce_idle", 16'h0);
      step(10);

      // Long press on button 3
      c0 = cyc;
      btn_in = 4'b1000;
      push_range(c0 + 1, c0 + 5, "long_pre", 16'h0);
      push(c0 + 6, "long_press", pk(4'b1000, 4'b1000, 4'b0000, 4'b0000));
      push_range(c0 + 7, c0 + 21, "long_lvl", pk(4'b1000, 4'b0000, 4'b0000, 4'b0000));
      push_range(c0 + 22, c0 + 45, "long_hold", pk(4'b1000, 4'b0000, 4'b0000, 4'b1000));
      push(c0 + 46, "long_rel", pk(4'b0000, 4'b0000, 4'b1000, 4'b0000));
      push_range(c0 + 47, c0 + 50, "long_idle", 16'h0);
      step(40);
      btn_in = 4'b0000;
      step(12);

      // Simultaneous press on buttons 0 and 2
      c0 = cyc;
      btn_in = 4'b0101;
      push_range(c0 + 1, c0 + 5, "simul_pre", 16'h0);
      push(c0 + 6, "simul_press", pk(4'b0101, 4'b0101, 4'b0000, 4'b0000));
      push_range(c0 + 7, c0 + 8, "simul_lvl", pk(4'b0101, 4'b0000, 4'b0000, 4'b0000));
      step(8);
      c1 = cyc;
      btn_in = 4'b0000;
      push_range(c1 + 1, c1 + 5, "simul_rel_pre", pk(4'b0101, 4'b0000, 4'b0000, 4'b0000));
      push(c1 + 6, "simul_rel", pk(4'b0000, 4'b0000, 4'b0101, 4'b0000));
      push(c1 + 7, "simul_idle", 16'h0);
      step(9);

      // Reset in the middle of a hold count
      c0 = cyc;
      btn_in = 4'b1000;
      push_range(c0 + 1, c0 + 5, "mid_pre", 16'h0);
      push(c0 + 6, "mid_press", pk(4'b1000, 4'b1000, 4'b0000, 4'b0000));
      push_range(c0 + 7, c0 + 15, "mid_lvl", pk(4'b1000, 4'b0000, 4'b0000, 4'b0000));
      step(16);
      #1 reset = 1'b1;
      #1 check("mid_rst_async", {16'h0, dut_out}, 32'h0);
      push_range(c0 + 17, c0 + 18, "mid_rst_hold", 16'h0);
      step(2);
      reset = 1'b0;
      r = cyc;
      push_range(r + 1, r + 5, "mid_quiet", 16'h0);
      push(r + 6, "mid_repress", pk(4'b1000, 4'b1000, 4'b0000, 4'b0000));
      push_range(r + 7, r + 21, "mid_relvl", pk(4'b1000, 4'b0000, 4'b0000, 4'b0000));
      push_range(r + 22, r + 35, "mid_hold", pk(4'b1000, 4'b0000, 4'b0000, 4'b1000));
      push(r + 36, "mid_rel", pk(4'b0000, 4'b0000, 4'b1000, 4'b0000));
      push_range(r + 37, r + 39, "mid_idle", 16'h0);
      step(30);
      btn_in = 4'b0000;
      step(12);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
